// File: rtl/vis_pkg.sv
// rtl/vis_pkg.sv - shared types and constants for the spectrum bar display path
package vis_pkg;

  localparam int NUM_BARS = 16;
  localparam int SEG_BITS = 18;

  typedef logic [SEG_BITS-1:0] bar_t;
  typedef logic [4:0]          level_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WAIT_VS,
    COMMIT
  } sched_state_t;

  // Segment k is lit when the bar level reaches above it; LSB is the bottom segment.
  function automatic bar_t thermo(input level_t lvl);
    bar_t w;
    for (int k = 0; k < SEG_BITS; k++) begin
      w[k] = (level_t'(k) < lvl);
    end
    return w;
  endfunction

endpackage

// File: rtl/bar_level_map.sv
// rtl/bar_level_map.sv - magnitude to bar level, and bar level to thermometer word
module bar_level_map
  import vis_pkg::*;
#(
  parameter int MAG_W = 8
) (
  input  logic [MAG_W-1:0] mag,
  input  level_t           lvl_in,
  output level_t           lvl,
  output bar_t             bar
);

  logic [MAG_W+4:0] prod;

  // Offsetting by one lets full-scale magnitude reach exactly SEG_BITS.
  assign prod = ({5'd0, mag} + (MAG_W+5)'(1)) * (MAG_W+5)'(SEG_BITS);
  assign lvl  = level_t'(prod >> MAG_W);
  assign bar  = thermo(lvl_in);

endmodule

// File: rtl/bar_frame_scheduler.sv
// rtl/bar_frame_scheduler.sv - collects a set of magnitude bins and commits them to
// the displayed bars at a vsync falling edge, with per-commit peak decay
module bar_frame_scheduler
  import vis_pkg::*;
#(
  parameter int MAG_W = 8,
  parameter int DECAY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         bin_valid,
  output logic                         bin_ready,
  input  logic [MAG_W-1:0]             bin_mag,
  input  logic                         bin_last,
  input  logic                         vsync,
  output logic [NUM_BARS*SEG_BITS-1:0] bars,
  output logic                         commit
);

  localparam int IDX_W = $clog2(NUM_BARS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BARS - 1);

  sched_state_t     state, next_state;
  logic [IDX_W-1:0] idx;
  level_t           shadow [NUM_BARS];
  level_t           disp   [NUM_BARS];
  logic             vs_q;

  logic   transfer, set_end, vs_start, last_write;
  level_t mag_lvl, decayed, new_lvl;
  bar_t   new_bar;

  bar_level_map #(.MAG_W(MAG_W)) u_map (
    .mag    (bin_mag),
    .lvl_in (new_lvl),
    .lvl    (mag_lvl),
    .bar    (new_bar)
  );

  assign transfer   = bin_valid && bin_ready;
  assign set_end    = transfer && (bin_last || idx == LAST_IDX);
  assign vs_start   = vs_q && !vsync;
  assign last_write = (state == COMMIT) && (idx == LAST_IDX);

  // Peak hold: a bar falls at most DECAY segments per commit, never below the new sample.
  assign decayed = (disp[idx] > level_t'(DECAY)) ? disp[idx] - level_t'(DECAY) : '0;
  assign new_lvl = (shadow[idx] > decayed) ? shadow[idx] : decayed;

  always_comb begin
    next_state = state;
    bin_ready  = 1'b0;
    case (state)
      IDLE:    next_state = COLLECT;
      COLLECT: begin
        bin_ready = 1'b1;
        if (set_end) next_state = WAIT_VS;
      end
      WAIT_VS: if (vs_start) next_state = COMMIT;
      COMMIT:  if (idx == LAST_IDX) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      vs_q   <= 1'b1;
      commit <= 1'b0;
      bars   <= '0;
      for (int k = 0; k < NUM_BARS; k++) begin
        shadow[k] <= '0;
        disp[k]   <= '0;
      end
    end else begin
      state  <= next_state;
      vs_q   <= vsync;
      commit <= last_write;
      case (state)
        COLLECT: begin
          if (transfer) begin
            shadow[idx] <= mag_lvl;
            if (set_end) begin
              idx <= '0;
              // A short set leaves no stale bins from the previous set.
              for (int k = 0; k < NUM_BARS; k++) begin
                if (k > int'(idx)) shadow[k] <= '0;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        COMMIT: begin
          disp[idx]                         <= new_lvl;
          bars[idx*SEG_BITS +: SEG_BITS]    <= new_bar;
          idx                               <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bar_frame_scheduler.sv
// tb/tb_bar_frame_scheduler.sv - directed, table-driven bench for bar_frame_scheduler
module tb_bar_frame_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         bin_valid;
  logic         bin_ready;
  logic [7:0]   bin_mag;
  logic         bin_last;
  logic         vsync;
  logic [287:0] bars;
  logic         commit;

  int tests = 0;
  int fails = 0;
  int commit_cnt = 0;

  typedef struct {
    logic [7:0] mag;
    int         lvl_e;
    int         lvl_g;
  } vec_t;
  vec_t tbl [16];

  bar_frame_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .bin_valid (bin_valid),
    .bin_ready (bin_ready),
    .bin_mag   (bin_mag),
    .bin_last  (bin_last),
    .vsync     (vsync),
    .bars      (bars),
    .commit    (commit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (commit === 1'b1) commit_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [17:0] word(input int lvl);
    return (18'(1) << lvl) - 18'd1;
  endfunction

  function automatic logic [17:0] bar_of(input int i);
    return bars[i*18 +: 18];
  endfunction

  task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bin(input logic [7:0] m, input logic l, output int stall);
    stall = 0;
    bin_valid = 1'b1;
    bin_mag = m;
    bin_last = l;
    while (bin_ready !== 1'b1 && stall < 50) begin
      @(negedge clk);
      stall++;
    end
    @(negedge clk);
    bin_valid = 1'b0;
    bin_last = 1'b0;
  endtask

  task automatic vs_commit(output int cyc);
    vsync = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (commit !== 1'b1 && cyc < 40);
    vsync = 1'b1;
  endtask

  initial begin
    int s, total, cyc, c0, lowcnt;

    tbl[0]  = '{8'd255, 18, 17};
    tbl[1]  = '{8'd0,    0,  9};
    tbl[2]  = '{8'd100,  7,  9};
    tbl[3]  = '{8'd200, 14, 13};
    tbl[4]  = '{8'd14,   1,  0};
    tbl[5]  = '{8'd13,   0,  0};
    tbl[6]  = '{8'd28,   2,  1};
    tbl[7]  = '{8'd50,   3,  2};
    tbl[8]  = '{8'd75,   5,  4};
    tbl[9]  = '{8'd127,  9,  8};
    tbl[10] = '{8'd150, 10,  9};
    tbl[11] = '{8'd169, 11, 10};
    tbl[12] = '{8'd170, 12, 11};
    tbl[13] = '{8'd230, 16, 15};
    tbl[14] = '{8'd241, 17, 16};
    tbl[15] = '{8'd240, 16, 15};

    rst = 1'b1; bin_valid = 1'b0; bin_mag = '0; bin_last = 1'b0; vsync = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_bars", bars, '0);
    check("reset_commit", commit, 1'b0);
    check("reset_ready", bin_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("collect_after_reset", bin_ready, 1'b1);

    // Full-scale set, one bin per cycle.
    total = 0;
    for (int i = 0; i < 16; i++) begin
      send_bin(8'd255, i == 15, s);
      total += s;
    end
    check("full_set_stalls", total, 0);
    check("wait_vs_ready_low", bin_ready, 1'b0);
    check("no_commit_before_vs", bars, '0);
    c0 = commit_cnt;
    vsync = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 9) begin
        check("mid_commit_bar7", bar_of(7), 18'h3FFFF);
        check("mid_commit_bar8", bar_of(8), 18'h00000);
      end
    end while (commit !== 1'b1 && cyc < 40);
    vsync = 1'b1;
    check("first_commit_latency", cyc, 17);
    check("first_commit_bars", bars, {16{18'h3FFFF}});
    @(negedge clk);
    check("commit_pulse_ends", commit, 1'b0);
    check("commit_pulse_once", commit_cnt - c0, 1);

    // Zero sets: displayed level decays by one per commit.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) send_bin(8'd0, i == 15, s);
      vs_commit(cyc);
      check("decay_latency", cyc, 17);
      check("decay_bars", bars, {16{word(17 - r)}});
    end
    check("decay_bar0_third", bar_of(0), 18'h07FFF);

    // Vsync edge while the set is still arriving is ignored.
    c0 = commit_cnt;
    for (int i = 0; i < 4; i++) send_bin(8'd255, 1'b0, s);
    vsync = 1'b0;
    for (int i = 4; i < 8; i++) send_bin(8'd255, 1'b0, s);
    repeat (3) @(negedge clk);
    check("vs_in_collect_no_commit", commit_cnt - c0, 0);
    check("vs_in_collect_bars_hold", bars, {16{18'h07FFF}});
    vsync = 1'b1;
    for (int i = 8; i < 16; i++) send_bin(8'd255, i == 15, s);
    vs_commit(cyc);
    check("next_edge_latency", cyc, 17);
    check("next_edge_bars", bars, {16{18'h3FFFF}});
    check("next_edge_one_commit", commit_cnt - c0, 1);

    // Reset in the middle of a commit.
    for (int i = 0; i < 16; i++) send_bin(8'd0, i == 15, s);
    c0 = commit_cnt;
    vsync = 1'b0;
    repeat (8) @(negedge clk);
    check("partial_commit_bar0", bar_of(0), 18'h1FFFF);
    rst = 1'b1;
    vsync = 1'b1;
    @(negedge clk);
    check("rst_commit_bars", bars, '0);
    check("rst_commit_pulse", commit, 1'b0);
    check("rst_commit_ready", bin_ready, 1'b0);
    check("rst_commit_no_pulse", commit_cnt - c0, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_collect", bin_ready, 1'b1);

    // Mixed magnitudes, a 10-cycle valid gap, set ended by the count alone.
    for (int i = 0; i < 16; i++) begin
      send_bin(tbl[i].mag, 1'b0, s);
      if (i == 5) begin
        lowcnt = 0;
        repeat (10) begin
          @(negedge clk);
          if (bin_ready !== 1'b1) lowcnt++;
        end
        check("gap_ready_held", lowcnt, 0);
        check("gap_no_writes", bars, '0);
      end
    end
    check("count_end_ready_low", bin_ready, 1'b0);
    vs_commit(cyc);
    check("table_latency", cyc, 17);
    for (int i = 0; i < 16; i++) check($sformatf("table_bar%0d", i), bar_of(i), word(tbl[i].lvl_e));

    // Short set: four bins, remaining bars only decay.
    for (int i = 0; i < 4; i++) send_bin(8'd127, i == 3, s);
    check("short_set_ready_low", bin_ready, 1'b0);
    vs_commit(cyc);
    check("short_latency", cyc, 17);
    for (int i = 0; i < 16; i++) check($sformatf("short_bar%0d", i), bar_of(i), word(tbl[i].lvl_g));
    check("short_bar1_lvl9", bar_of(1), 18'h001FF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
